// File: rtl/chart_scheduler_pkg.sv
// Shared definitions for the chart playback scheduler.
// Entry layout is {end, lanes[LANES-1:0], time[TIME_W-1:0]}; helpers locate fields for any TIME_W.
// Scheduler states are shared so tooling and sub-blocks agree on the encoding.
package chart_scheduler_pkg;

    localparam int LANES    = 4;
    localparam int TIME_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DONE
    } sched_state_t;

    // Lane mask sits directly above the timestamp.
    function automatic int lane_lsb(input int time_w);
        return TIME_LSB + time_w;
    endfunction

    // End-of-chart flag is the top bit of an entry.
    function automatic int end_bit(input int time_w);
        return TIME_LSB + time_w + LANES;
    endfunction

endpackage

// File: rtl/chart_scheduler_song_timer.sv
// Song clock: saturating tick counter with synchronous clear.
// Latency: count visible the cycle after an accepted increment.
// Backpressure: none; increments are dropped while inc_i is low or at all-ones.
module chart_scheduler_song_timer #(
    parameter int TIME_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [TIME_W-1:0] time_o
);

    logic [TIME_W-1:0] time_q, time_d;

    // Clear wins over increment; the counter sticks at all-ones instead of wrapping.
    always_comb begin
        time_d = time_q;
        if (clear_i) begin
            time_d = '0;
        end else if (inc_i && (time_q != '1)) begin
            time_d = time_q + 1'b1;
        end
    end

    // Song time register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            time_q <= '0;
        end else begin
            time_q <= time_d;
        end
    end

    assign time_o = time_q;

endmodule

// File: rtl/chart_scheduler.sv
// Chart playback: walks chart ROM and emits per-lane spawn pulses LEAD ticks before each hit time.
// Latency: spawn combinational in HOLD; next ROM fetch the following cycle; ROM_LAT+2 cycles per entry.
// Backpressure: pause freezes song time and holds the pending entry; start restarts from address 0.
module chart_scheduler
    import chart_scheduler_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int TIME_W  = 24,
    parameter int LEAD    = 480,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic                      pause_i,
    input  logic                      tick_i,
    input  logic [TIME_W+LANES:0]     rom_data_i,
    output logic                      rd_en_o,
    output logic [ADDR_W-1:0]         read_addr_o,
    output logic [LANES-1:0]          spawn_o,
    output logic [TIME_W-1:0]         song_time_o,
    output logic [15:0]               note_cnt_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int                END_BIT  = end_bit(TIME_W);
    localparam int                LANE_LSB = lane_lsb(TIME_W);
    localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [TIME_W:0]   LEAD_EXT = (TIME_W + 1)'(LEAD);

    sched_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [1:0]         lat_q, lat_d;
    logic               ent_end_q, ent_end_d;
    logic [LANES-1:0]   ent_lanes_q, ent_lanes_d;
    logic [TIME_W-1:0]  ent_time_q, ent_time_d;
    logic               due;

    // Extra top bit so song_time+LEAD near saturation never wraps past the entry time.
    assign due = ({1'b0, ent_time_q} <= ({1'b0, song_time_o} + LEAD_EXT));

    // Next-state, datapath updates and spawn pulse; start overrides everything else.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        lat_d       = lat_q;
        ent_end_d   = ent_end_q;
        ent_lanes_d = ent_lanes_q;
        ent_time_d  = ent_time_q;
        spawn_o     = '0;
        if (start_i) begin
            state_d = FETCH;
            addr_d  = '0;
            cnt_d   = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    lat_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        ent_end_d   = rom_data_i[END_BIT];
                        ent_lanes_d = rom_data_i[LANE_LSB +: LANES];
                        ent_time_d  = rom_data_i[TIME_LSB +: TIME_W];
                        state_d     = HOLD;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (ent_end_q) begin
                        state_d = DONE;
                    end else if (due && !pause_i) begin
                        spawn_o = ent_lanes_q;
                        if ((ent_lanes_q != '0) && (cnt_q != 16'hFFFF)) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        // Last ROM slot consumed: finish without wrapping the address.
                        if (addr_q == ADDR_MAX) begin
                            state_d = DONE;
                        end else begin
                            addr_d  = addr_q + 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Control and entry registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            ent_end_q   <= 1'b0;
            ent_lanes_q <= '0;
            ent_time_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            ent_end_q   <= ent_end_d;
            ent_lanes_q <= ent_lanes_d;
            ent_time_q  <= ent_time_d;
        end
    end

    assign rd_en_o     = (state_q == FETCH);
    assign busy_o      = (state_q == FETCH) || (state_q == WAIT) || (state_q == HOLD);
    assign done_o      = (state_q == DONE);
    assign read_addr_o = addr_q;
    assign note_cnt_o  = cnt_q;

    chart_scheduler_song_timer #(
        .TIME_W (TIME_W)
    ) u_song_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (start_i),
        .inc_i   (tick_i && busy_o && !pause_i),
        .time_o  (song_time_o)
    );

endmodule

// File: tb/tb_chart_scheduler.sv
// Bench for chart_scheduler: ROM model, event-level playback model, directed and random scenarios.
// Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
// All waits are cycle-bounded and report a failure on expiry.
module tb_chart_scheduler;

    localparam int ADDR_W  = 11;
    localparam int TIME_W  = 24;
    localparam int LEAD    = 480;
    localparam int ROM_LAT = 1;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam longint TMAX = (64'd1 << TIME_W) - 1;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
    logic [TIME_W+4:0] rom_data = '0;
    logic rd_en, busy, done;
    logic [ADDR_W-1:0] read_addr;
    logic [3:0] spawn;
    logic [TIME_W-1:0] song_time;
    logic [15:0] note_cnt;

    chart_scheduler #(.ADDR_W(ADDR_W), .TIME_W(TIME_W), .LEAD(LEAD), .ROM_LAT(ROM_LAT)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pause_i(pause), .tick_i(tick),
        .rom_data_i(rom_data), .rd_en_o(rd_en), .read_addr_o(read_addr), .spawn_o(spawn),
        .song_time_o(song_time), .note_cnt_o(note_cnt), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // Chart ROM with one cycle of read latency.
    logic [TIME_W+4:0] rom [0:DEPTH-1];
    always @(posedge clk) if (rd_en) rom_data <= rom[read_addr];

    int errors = 0, checks = 0;
    int tick_mode = 0;  // 0 none, 1 every cycle, 2 random

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [TIME_W+4:0] ent(input bit e, input logic [3:0] l, input longint t);
        return {e, l, t[TIME_W-1:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = ent(1'b1, 4'b0, 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (tick_mode)
            1: tick = 1'b1;
            2: tick = 1'($urandom_range(0, 1));
            default: tick = 1'b0;
        endcase
    end

    // Playback model: entries become visible ROM_LAT+2 cycles after start or after the previous spawn.
    longint cyc = 0, m_time = 0, m_avail = 0;
    int m_cnt = 0, m_addr = 0;
    bit m_play = 0, m_done = 0;
    longint lg_cyc[$], lg_time[$];
    int lg_lanes[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            m_play = 0; m_done = 0; m_time = 0; m_cnt = 0; m_addr = 0; m_avail = 0;
        end else begin
            bit n_play, n_done, e_rd;
            longint n_time, n_avail;
            int n_cnt, n_addr, e_spawn;
            logic [TIME_W+4:0] e;
            n_play = m_play; n_done = m_done; n_time = m_time; n_avail = m_avail;
            n_cnt = m_cnt; n_addr = m_addr; e_spawn = 0;
            e_rd = m_play && (cyc == m_avail - ROM_LAT - 1);
            if (start) begin
                n_play = 1; n_done = 0; n_time = 0; n_cnt = 0; n_addr = 0;
                n_avail = cyc + ROM_LAT + 2;
            end else begin
                if (m_play && cyc >= m_avail) begin
                    e = rom[m_addr];
                    if (e[TIME_W+4]) begin
                        n_play = 0; n_done = 1;
                    end else if (!pause && longint'(e[TIME_W-1:0]) <= m_time + LEAD) begin
                        e_spawn = int'(e[TIME_W+3:TIME_W]);
                        if (e_spawn != 0 && m_cnt < 65535) n_cnt = m_cnt + 1;
                        if (m_addr == DEPTH - 1) begin
                            n_play = 0; n_done = 1;
                        end else begin
                            n_addr = m_addr + 1;
                            n_avail = cyc + ROM_LAT + 2;
                        end
                    end
                end
                if (tick && m_play && !pause && m_time < TMAX) n_time = m_time + 1;
            end
            chk("spawn", spawn, e_spawn);
            chk("rd_en", rd_en, e_rd);
            chk("busy", busy, m_play);
            chk("done", done, m_done);
            chk("song_time", song_time, m_time);
            chk("note_cnt", note_cnt, m_cnt);
            chk("read_addr", read_addr, m_addr);
            if (spawn != 0) begin
                lg_cyc.push_back(cyc); lg_time.push_back(song_time); lg_lanes.push_back(spawn);
            end
            m_play = n_play; m_done = n_done; m_time = n_time; m_avail = n_avail;
            m_cnt = n_cnt; m_addr = n_addr;
        end
        cyc++;
    end

    task automatic step(); @(posedge clk); #1; endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin step(); n++; end
        chk(name, done, 1);
    endtask

    task automatic wait_addr(input int a, input int budget, input string name);
        int n = 0;
        while (read_addr != a && n < budget) begin step(); n++; end
        chk(name, read_addr, a);
    endtask

    initial begin
        clear_rom();
        #3;
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rd_en", rd_en, 0);
        chk("rst_spawn", spawn, 0); chk("rst_addr", read_addr, 0); chk("rst_cnt", note_cnt, 0);
        step(); step(); rst_n = 1'b1; step();

        // Single note due immediately at time 0, then end marker.
        clear_rom(); rom[0] = ent(0, 4'b0001, 480);
        tick_mode = 0; lg_cyc.delete(); lg_time.delete(); lg_lanes.delete();
        pulse_start(); wait_done(50, "t2_done");
        chk("t2_nspawn", lg_lanes.size(), 1);
        if (lg_lanes.size() == 1) begin
            chk("t2_lanes", lg_lanes[0], 4'b0001); chk("t2_time", lg_time[0], 0);
        end
        chk("t2_cnt", note_cnt, 1); chk("t2_addr", read_addr, 1);

        // Multi-lane entry must fire exactly when song_time+LEAD reaches its time.
        clear_rom(); rom[0] = ent(0, 4'b1011, 1000);
        tick_mode = 1; lg_cyc.delete(); lg_time.delete(); lg_lanes.delete();
        pulse_start(); wait_done(2000, "t3_done");
        chk("t3_nspawn", lg_lanes.size(), 1);
        if (lg_lanes.size() == 1) begin
            chk("t3_lanes", lg_lanes[0], 4'b1011); chk("t3_time", lg_time[0], 520);
        end

        // Pause freezes time and spawning.
        clear_rom(); rom[0] = ent(0, 4'b0100, 2000);
        lg_cyc.delete(); lg_time.delete(); lg_lanes.delete();
        pulse_start();
        begin
            int n = 0;
            while (song_time != 100 && n < 500) begin step(); n++; end
        end
        chk("t4_reach", song_time, 100);
        pause = 1'b1; repeat (50) step();
        chk("t4_frozen", song_time, 100); chk("t4_nospawn", lg_lanes.size(), 0);
        pause = 1'b0; repeat (10) step();
        chk("t4_resume", song_time, 110);
        wait_done(3000, "t4_done");
        if (lg_time.size() == 1) chk("t4_time", lg_time[0], 1520);
        else chk("t4_nspawn", lg_time.size(), 1);

        // Equal-time entries plus a silent lanes==0 entry.
        clear_rom();
        rom[0] = ent(0, 4'b0010, 600); rom[1] = ent(0, 4'b0100, 600); rom[2] = ent(0, 4'b0000, 600);
        lg_cyc.delete(); lg_time.delete(); lg_lanes.delete();
        pulse_start(); wait_done(1000, "t5_done");
        chk("t5_nspawn", lg_lanes.size(), 2);
        if (lg_lanes.size() == 2) chk("t5_gap", lg_cyc[1] - lg_cyc[0], ROM_LAT + 2);
        chk("t5_cnt", note_cnt, 2); chk("t5_addr", read_addr, 3);

        // Restart while holding at address 7.
        clear_rom();
        for (int i = 0; i < 7; i++) rom[i] = ent(0, 4'(i + 1), 0);
        rom[7] = ent(0, 4'b0001, 60000);
        tick_mode = 0;
        pulse_start(); wait_addr(7, 100, "t6_addr7");
        tick_mode = 1; repeat (5) step();
        chk("t6_cnt_before", note_cnt, 7); chk("t6_busy", busy, 1);
        pulse_start();
        chk("t6_rd_en", rd_en, 1); chk("t6_addr", read_addr, 0);
        chk("t6_time", song_time, 0); chk("t6_cnt", note_cnt, 0);

        // Asynchronous reset while holding.
        wait_addr(7, 100, "t1_addr7"); repeat (5) step();
        @(posedge clk); #3; rst_n = 1'b0; #1;
        chk("t1_busy", busy, 0); chk("t1_rd_en", rd_en, 0); chk("t1_spawn", spawn, 0);
        chk("t1_addr", read_addr, 0); chk("t1_time", song_time, 0); chk("t1_done", done, 0);
        step(); step(); rst_n = 1'b1; step();

        // Full ROM without an end flag: stops at the last address.
        for (int i = 0; i < DEPTH; i++) rom[i] = ent(0, 4'(i), 0);
        tick_mode = 2;
        pulse_start(); wait_done(10000, "wrap_done");
        chk("wrap_addr", read_addr, DEPTH - 1); chk("wrap_cnt", note_cnt, 1920);

        // Random charts with random ticks, pauses and occasional restarts.
        for (int r = 0; r < 4; r++) begin
            longint t;
            int n;
            clear_rom();
            t = 400 + $urandom_range(0, 200);
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) != 0) t = t + $urandom_range(0, 30);
                rom[i] = ent(0, 4'($urandom_range(0, 15)), t);
            end
            pulse_start();
            n = 0;
            while (!done && n < 4000) begin
                pause = ($urandom_range(0, 9) == 0);
                start = ($urandom_range(0, 399) == 0);
                step(); n++;
            end
            pause = 1'b0; start = 1'b0;
            chk("rand_done", done, 1);
        end

        tick_mode = 0; step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
